frost32_lsu: RTL

FROST32_LSU -- requirements
Module: frost32_lsu

---
 rtl/frost32_lsu_pkg.sv | 65 ++++++
 rtl/frost32_lsu_lane.sv | 58 +++++
 rtl/frost32_lsu.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/frost32_lsu_pkg.sv
// Shared types for the FROST32 load/store unit: access encoding, FSM
// states, the latched request record and small classification helpers.
package frost32_lsu_pkg;

    // Load/store encoding as produced by the instruction decoder.
    typedef enum logic [2:0] {
        LD32  = 3'd0,
        LDU16 = 3'd1,
        LDS16 = 3'd2,
        LDU8  = 3'd3,
        LDS8  = 3'd4,
        ST32  = 3'd5,
        ST16  = 3'd6,
        ST8   = 3'd7
    } ldst_type_e;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_8  = 2'd0,
        SIZE_16 = 2'd1,
        SIZE_32 = 2'd2
    } access_size_e;

    // Bus cycles an access may wait for mem_ack before it is abandoned.
    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    // Request captured on acceptance and held for the whole access.
    typedef struct packed {
        ldst_type_e  ldst_type;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rd_index;
    } lsu_req_t;

    function automatic access_size_e access_size(input ldst_type_e t);
        access_size_e s;
        case (t)
            LD32, ST32:         s = SIZE_32;
            LDU16, LDS16, ST16: s = SIZE_16;
            default:            s = SIZE_8;
        endcase
        return s;
    endfunction

    function automatic logic is_store(input ldst_type_e t);
        return (t == ST32) || (t == ST16) || (t == ST8);
    endfunction

    // Words need a 4-byte boundary, halfwords a 2-byte one, bytes anything.
    function automatic logic is_aligned(input ldst_type_e t, input logic [1:0] offset);
        logic ok;
        case (access_size(t))
            SIZE_32: ok = (offset == 2'b00);
            SIZE_16: ok = (offset[0] == 1'b0);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/frost32_lsu_lane.sv
// Byte-lane logic for the LSU: little-endian byte enables, store data
// replication into every lane, and load lane selection with extension.
module frost32_lsu_lane
    import frost32_lsu_pkg::*;
(
    input  ldst_type_e  ldst_type,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Byte enables: full word, the halfword picked by offset[1], or one lane.
    always_comb begin
        byte_en = 4'b0000;
        case (access_size(ldst_type))
            SIZE_32: byte_en = 4'b1111;
            SIZE_16: byte_en = offset[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b0001 << offset;
        endcase
    end

    // Store data copied into every lane so the enables alone pick the bytes.
    always_comb begin
        store_data = wdata;
        case (access_size(ldst_type))
            SIZE_32: store_data = wdata;
            SIZE_16: store_data = {2{wdata[15:0]}};
            default: store_data = {4{wdata[7:0]}};
        endcase
    end

    // Load path: pick the addressed lane(s), then zero- or sign-extend.
    always_comb begin
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_sel  = rdata[7:0];
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        load_data = rdata;
        case (ldst_type)
            LDU16:   load_data = {16'h0000, half_sel};
            LDS16:   load_data = {{16{half_sel[15]}}, half_sel};
            LDU8:    load_data = {24'h000000, byte_sel};
            LDS8:    load_data = {{24{byte_sel[7]}}, byte_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/frost32_lsu.sv
// FROST32 load/store unit: accepts one decoded load/store at a time, runs a
// single memory access with timeout, and reports completion or error.
//
// Request handshake: a request transfers on a rising edge where req_valid
// and req_ready are both high; req_ready is high only in IDLE, so the
// request fields need only be valid in that cycle (they are latched).
module frost32_lsu
    import frost32_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_ldst_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_rd_index,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [3:0]  res_rd_index,
    output logic        st_done,
    output logic        err_misalign,
    output logic        err_bus,
    output logic        busy,
    output lsu_state_e  state
);

    // Count value seen on the last permitted ack-less ACCESS cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_req_t    cur;
    logic [7:0]  timeout_cnt;
    ldst_type_e  in_type;
    logic [3:0]  lane_byte_en;
    logic [31:0] lane_store_data;
    logic [31:0] lane_load_data;

    assign in_type   = ldst_type_e'(req_ldst_type);
    assign req_ready = (state == LSU_IDLE);
    assign busy      = ~req_ready;

    // Lane logic always works on the latched request, so the bus fields
    // and the load extraction stay stable for the whole access.
    frost32_lsu_lane u_lane (
        .ldst_type  (cur.ldst_type),
        .offset     (cur.addr[1:0]),
        .wdata      (cur.wdata),
        .rdata      (mem_rdata),
        .byte_en    (lane_byte_en),
        .store_data (lane_store_data),
        .load_data  (lane_load_data)
    );

    // Bus fields are derived from the registered request and qualified by the
    // registered mem_req, so they are constant while mem_req is high and zero
    // whenever no access is outstanding (including straight after reset).
    always_comb begin
        mem_we      = mem_req & is_store(cur.ldst_type);
        mem_addr    = mem_req ? {cur.addr[31:2], 2'b00} : 32'h0000_0000;
        mem_byte_en = mem_req ? lane_byte_en : 4'b0000;
        mem_wdata   = mem_req ? lane_store_data : 32'h0000_0000;
    end

    // Control FSM: accept, access with timeout, one-cycle response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LSU_IDLE;
            cur          <= '0;
            timeout_cnt  <= 8'd0;
            mem_req      <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= 32'h0000_0000;
            res_rd_index <= 4'h0;
            st_done      <= 1'b0;
            err_misalign <= 1'b0;
            err_bus      <= 1'b0;
        end else begin
            res_valid    <= 1'b0;
            st_done      <= 1'b0;
            err_misalign <= 1'b0;
            err_bus      <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        if (is_aligned(in_type, req_addr[1:0])) begin
                            cur.ldst_type <= in_type;
                            cur.addr      <= req_addr;
                            cur.wdata     <= req_wdata;
                            cur.rd_index  <= req_rd_index;
                            timeout_cnt   <= 8'd0;
                            mem_req       <= 1'b1;
                            state         <= LSU_ACCESS;
                        end else begin
                            // Misaligned: report directly, never touch the bus.
                            err_misalign <= 1'b1;
                            state        <= LSU_RESP;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        timeout_cnt <= 8'd0;
                        if (is_store(cur.ldst_type)) begin
                            st_done <= 1'b1;
                        end else begin
                            res_valid    <= 1'b1;
                            res_data     <= lane_load_data;
                            res_rd_index <= cur.rd_index;
                        end
                        state <= LSU_RESP;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        // This is the TIMEOUT_CYCLES-th cycle without an ack.
                        mem_req     <= 1'b0;
                        timeout_cnt <= 8'd0;
                        err_bus     <= 1'b1;
                        state       <= LSU_RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                LSU_RESP: begin
                    state <= LSU_IDLE;
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule
